// File: rtl/db_multi.sv
// Multi-channel switch debouncer: per-channel 2-flop synchronizer, four-state debounce FSM,
// registered level/rise/fall outputs and a long-press detector driven by a saturating hold counter.
module db_multi #(
    parameter int CH       = 4,
    parameter int DB_CNT   = 2000000,
    parameter int LONG_CNT = 50000000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] sw,
    output logic [CH-1:0] db_level,
    output logic [CH-1:0] rise_tick,
    output logic [CH-1:0] fall_tick,
    output logic [CH-1:0] long_tick
);

    localparam int DW = $clog2(DB_CNT + 1);
    localparam int HW = $clog2(LONG_CNT + 1);
    localparam logic [DW-1:0] DB_LOAD  = DW'(DB_CNT - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CNT);
    localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CNT - 1);

    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

    logic [CH-1:0] r_sync1;
    logic [CH-1:0] r_sync2;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        state_t        r_state, w_state_nxt;
        logic [DW-1:0] r_db_cnt, w_db_cnt_nxt;
        logic [HW-1:0] r_hold, w_hold_nxt;
        logic          w_sw_s, w_rise, w_fall, w_long;
        logic          r_db, r_rise, r_fall, r_long;

        assign w_sw_s = r_sync2[g];
        assign w_rise = (r_state == WAIT1) && (w_state_nxt == ONE);
        assign w_fall = (r_state == WAIT0) && (w_state_nxt == ZERO);

        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        always_comb begin
            w_state_nxt  = r_state;
            w_db_cnt_nxt = r_db_cnt;
            w_hold_nxt   = r_hold;
            w_long       = 1'b0;

            case (r_state)
                ZERO: begin
                    if (w_sw_s) begin
                        w_state_nxt  = WAIT1;
                        w_db_cnt_nxt = DB_LOAD;
                    end
                end
                WAIT1: begin
                    if (!w_sw_s)              w_state_nxt  = ZERO;
                    else if (r_db_cnt == '0)  w_state_nxt  = ONE;
                    else                      w_db_cnt_nxt = r_db_cnt - DW'(1);
                end
                ONE: begin
                    if (!w_sw_s) begin
                        w_state_nxt  = WAIT0;
                        w_db_cnt_nxt = DB_LOAD;
                    end
                end
                WAIT0: begin
                    if (w_sw_s)               w_state_nxt  = ONE;
                    else if (r_db_cnt == '0)  w_state_nxt  = ZERO;
                    else                      w_db_cnt_nxt = r_db_cnt - DW'(1);
                end
                default: w_state_nxt = ZERO;
            endcase

            // Hold time spans ONE and WAIT0, so an aborted release keeps counting.
            if (w_state_nxt == ZERO || w_rise) begin
                w_hold_nxt = '0;
            end else if ((r_state == ONE || r_state == WAIT0) && r_hold != HOLD_MAX) begin
                w_hold_nxt = r_hold + HW'(1);
                w_long     = (r_hold == HOLD_PRE);
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_state  <= ZERO;
                r_db_cnt <= '0;
                r_hold   <= '0;
                r_db     <= 1'b0;
                r_rise   <= 1'b0;
                r_fall   <= 1'b0;
                r_long   <= 1'b0;
            end else begin
                r_state  <= w_state_nxt;
                r_db_cnt <= w_db_cnt_nxt;
                r_hold   <= w_hold_nxt;
                r_db     <= (w_state_nxt == ONE) || (w_state_nxt == WAIT0);
                r_rise   <= w_rise;
                r_fall   <= w_fall;
                r_long   <= w_long;
            end
        end

        assign db_level[g]  = r_db;
        assign rise_tick[g] = r_rise;
        assign fall_tick[g] = r_fall;
        assign long_tick[g] = r_long;
    end

endmodule

// File: tb/tb_db_multi.sv
// Bench for db_multi: directed scenarios plus randomized switch activity, every cycle compared
// against a run-length behavioural model of debounce and press-hold timing.
module tb_db_multi;

    localparam int CH = 4;
    localparam int DB = 4;
    localparam int LG = 10;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] sw;
    logic [CH-1:0] db_level, rise_tick, fall_tick, long_tick;

    db_multi #(.CH(CH), .DB_CNT(DB), .LONG_CNT(LG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .db_level  (db_level),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .long_tick (long_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: two-stage sample delay, run length of samples opposing the accepted level,
    // and cycles spent pressed since the accepted rise.
    int m_s1[CH], m_s2[CH], m_level[CH], m_run[CH], m_held[CH];
    logic [CH-1:0] e_db, e_rise, e_fall, e_long;
    int long_seen[CH];

    task automatic check(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic model_step();
        for (int c = 0; c < CH; c++) begin
            int sw_s;
            int was_high;
            e_rise[c] = 1'b0;
            e_fall[c] = 1'b0;
            e_long[c] = 1'b0;
            if (!rst_n) begin
                m_s1[c] = 0; m_s2[c] = 0; m_level[c] = 0; m_run[c] = 0; m_held[c] = 0;
            end else begin
                sw_s     = m_s2[c];
                m_s2[c]  = m_s1[c];
                m_s1[c]  = int'(sw[c]);
                was_high = m_level[c];
                if (sw_s != m_level[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DB + 1) begin
                        m_level[c] = sw_s;
                        m_run[c]   = 0;
                        if (sw_s == 1) e_rise[c] = 1'b1;
                        else           e_fall[c] = 1'b1;
                    end
                end else begin
                    m_run[c] = 0;
                end
                if (e_rise[c] || e_fall[c]) begin
                    m_held[c] = 0;
                end else if (was_high == 1 && m_held[c] < LG) begin
                    m_held[c]++;
                    if (m_held[c] == LG) e_long[c] = 1'b1;
                end
            end
            e_db[c] = (m_level[c] == 1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("db_level",  db_level,  e_db);
        check("rise_tick", rise_tick, e_rise);
        check("fall_tick", fall_tick, e_fall);
        check("long_tick", long_tick, e_long);
        for (int c = 0; c < CH; c++) long_seen[c] += int'(long_tick[c]);
    endtask

    initial begin
        rst_n = 1'b0;
        sw    = '0;
        for (int c = 0; c < CH; c++) long_seen[c] = 0;
        e_db = '0; e_rise = '0; e_fall = '0; e_long = '0;

        repeat (2) tick();
        check("reset_db", db_level, '0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Clean press on channel 0
        sw[0] = 1'b1;
        repeat (6) tick();
        check("press_early", rise_tick, '0);
        tick();
        check("press_rise", rise_tick, 4'b0001);
        check("press_db",   db_level,  4'b0001);

        // Bounce on channel 1
        sw[1] = 1'b1; repeat (3) tick();
        sw[1] = 1'b0; tick();
        sw[1] = 1'b1;
        repeat (6) begin
            tick();
            check("bounce_quiet", rise_tick[1], 1'b0);
        end
        tick();
        check("bounce_rise", rise_tick[1], 1'b1);

        // Long press and release on channel 2
        sw[2] = 1'b1;
        repeat (7) tick();
        check("long_rise", rise_tick[2], 1'b1);
        long_seen[2] = 0;
        repeat (9) begin
            tick();
            check("long_early", long_tick[2], 1'b0);
        end
        tick();
        check("long_tick", long_tick[2], 1'b1);
        repeat (5) tick();
        sw[2] = 1'b0;
        repeat (6) begin
            tick();
            check("rel_early", fall_tick[2], 1'b0);
        end
        tick();
        check("rel_fall", fall_tick[2], 1'b1);
        repeat (12) tick();
        check("long_once", CH'(long_seen[2]), CH'(1));

        // Release glitch on channel 3
        sw[3] = 1'b1;
        repeat (7) tick();
        check("glitch_rise", rise_tick[3], 1'b1);
        long_seen[3] = 0;
        repeat (2) tick();
        sw[3] = 1'b0; repeat (2) tick();
        sw[3] = 1'b1;
        repeat (14) begin
            tick();
            check("glitch_db",   db_level[3],  1'b1);
            check("glitch_fall", fall_tick[3], 1'b0);
        end
        check("glitch_long", CH'(long_seen[3]), CH'(1));

        // Reset during WAIT1 of channel 0
        sw = '0;
        repeat (12) tick();
        sw[0] = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check("rst_db",   db_level,  '0);
        check("rst_rise", rise_tick, '0);
        rst_n = 1'b1;
        repeat (6) begin
            tick();
            check("rst_quiet", rise_tick, '0);
        end
        tick();
        check("rst_rise_after", rise_tick, 4'b0001);

        // Simultaneous press on all channels
        sw = '0;
        repeat (12) tick();
        sw = '1;
        repeat (6) tick();
        tick();
        check("simul_rise", rise_tick, 4'b1111);
        repeat (12) tick();

        // Randomized bouncing with occasional resets
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 11) == 0) sw[c] = ~sw[c];
            rst_n = ($urandom_range(0, 399) != 0);
            tick();
        end
        rst_n = 1'b1;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
